// File: rtl/country_vehicle_detector.sv
// Country-road vehicle detector: synchronizes and debounces the inductive
// loop, keeps a count of vehicles queued at the stop line, flags a loop that
// stays occupied too long, and raises the registered car-waiting request x.
module country_vehicle_detector #(
  parameter int DEBOUNCE    = 4,
  parameter int STUCK_LIMIT = 64,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             loop_raw,
  input  logic [1:0]       cntry,
  output logic             x,
  output logic [CNT_W-1:0] queue,
  output logic             fault
);

  localparam int DB_W  = $clog2(DEBOUNCE + 1);
  localparam int OCC_W = $clog2(STUCK_LIMIT + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] OCC   = 2'd1;
  localparam logic [1:0] STUCK = 2'd2;

  localparam logic [1:0] LIGHT_YELLOW = 2'd1;
  localparam logic [1:0] LIGHT_GREEN  = 2'd2;

  logic             sync_1;
  logic             loop_s;
  logic             loop_db;
  logic             loop_db_q;
  logic [DB_W-1:0]  db_cnt;
  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [OCC_W-1:0] occ_cnt;
  logic [OCC_W-1:0] occ_next;
  logic             fault_next;
  logic             rise;
  logic             fall;
  logic             arrive;
  logic             depart;
  logic [CNT_W-1:0] queue_next;

  // Two-flop synchronizer for the asynchronous loop input
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      sync_1 <= 1'b0;
      loop_s <= 1'b0;
    end else begin
      sync_1 <= loop_raw;
      loop_s <= sync_1;
    end
  end

  // Debounce: flip loop_db after DEBOUNCE consecutive disagreeing cycles;
  // loop_db_q keeps the previous value for edge detection
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      loop_db   <= 1'b0;
      loop_db_q <= 1'b0;
      db_cnt    <= '0;
    end else begin
      loop_db_q <= loop_db;
      if (loop_s != loop_db) begin
        // Toggling on the DEBOUNCE-1 -> DEBOUNCE step so the flip lands on
        // the same edge the count reaches DEBOUNCE.
        if (db_cnt == DB_W'(DEBOUNCE - 1)) begin
          loop_db <= ~loop_db;
          db_cnt  <= '0;
        end else begin
          db_cnt <= db_cnt + DB_W'(1);
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  // Occupancy FSM next-state: count occupied cycles and detect a stuck loop
  always_comb begin
    state_next = state;
    occ_next   = occ_cnt;
    case (state)
      IDLE: begin
        if (loop_db) begin
          state_next = OCC;
          occ_next   = OCC_W'(1);
        end
      end
      OCC: begin
        if (!loop_db) begin
          state_next = IDLE;
          occ_next   = '0;
        end else if (occ_cnt == OCC_W'(STUCK_LIMIT - 1)) begin
          state_next = STUCK;
          occ_next   = OCC_W'(STUCK_LIMIT);
        end else begin
          occ_next = occ_cnt + OCC_W'(1);
        end
      end
      STUCK: begin
        if (!loop_db) begin
          state_next = IDLE;
          occ_next   = '0;
        end
      end
      default: begin
        state_next = IDLE;
        occ_next   = '0;
      end
    endcase
    fault_next = (state_next == STUCK);
  end

  // Queue next value: arrivals under non-green, departures under green/yellow
  always_comb begin
    rise       = loop_db & ~loop_db_q;
    fall       = ~loop_db & loop_db_q;
    arrive     = rise & (cntry != LIGHT_GREEN);
    depart     = fall & ((cntry == LIGHT_GREEN) || (cntry == LIGHT_YELLOW));
    queue_next = queue;
    if (arrive && (queue != '1)) begin
      queue_next = queue + CNT_W'(1);
    end else if (depart && (queue != '0)) begin
      queue_next = queue - CNT_W'(1);
    end
  end

  // Registered state, queue and outputs; a stuck loop also requests service
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state   <= IDLE;
      occ_cnt <= '0;
      fault   <= 1'b0;
      queue   <= '0;
      x       <= 1'b0;
    end else begin
      state   <= state_next;
      occ_cnt <= occ_next;
      fault   <= fault_next;
      queue   <= queue_next;
      x       <= (queue_next != '0) | fault_next;
    end
  end

endmodule

// File: tb/tb_country_vehicle_detector.sv
// Testbench for country_vehicle_detector with default parameters.
module tb_country_vehicle_detector;

  logic       clk;
  logic       clr_n;
  logic       loop_raw;
  logic [1:0] cntry;
  logic       x;
  logic [3:0] queue;
  logic       fault;

  int errors;
  int checks;

  country_vehicle_detector #(
    .DEBOUNCE   (4),
    .STUCK_LIMIT(64),
    .CNT_W      (4)
  ) dut (
    .clk     (clk),
    .clr_n   (clr_n),
    .loop_raw(loop_raw),
    .cntry   (cntry),
    .x       (x),
    .queue   (queue),
    .fault   (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges; inputs are driven and outputs sampled on negedges.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    loop_raw = 1'b0;
    clr_n    = 1'b0;
    tick(2);
    clr_n = 1'b1;
    tick(3);
  endtask

  task automatic test_reset();
    loop_raw = 1'b0;
    cntry    = 2'd0;
    clr_n    = 1'b0;
    tick(3);
    checks++; if (queue !== 4'd0) begin errors++; $display("FAIL reset_queue: got %0d expected 0", queue); end
    checks++; if (x !== 1'b0) begin errors++; $display("FAIL reset_x: got %0b expected 0", x); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %0b expected 0", fault); end
    clr_n = 1'b1;
    tick(3);
    checks++; if (queue !== 4'd0 || x !== 1'b0) begin errors++; $display("FAIL post_reset: got queue=%0d x=%0b expected 0 0", queue, x); end
  endtask

  task automatic test_glitch();
    cntry    = 2'd0;
    loop_raw = 1'b1;
    tick(3);
    loop_raw = 1'b0;
    for (int t = 1; t <= 12; t++) begin
      tick(1);
      checks++; if (x !== 1'b0 || queue !== 4'd0) begin errors++; $display("FAIL glitch t=%0d: got queue=%0d x=%0b expected 0 0", t, queue, x); end
    end
  endtask

  // Three RED arrivals starting from an empty queue.
  task automatic test_arrivals();
    cntry = 2'd0;
    for (int v = 0; v < 3; v++) begin
      loop_raw = 1'b1;
      for (int t = 1; t <= 10; t++) begin
        tick(1);
        if (v == 0 && (t == 6 || t == 7)) begin
          checks++; if (x !== (t == 7)) begin errors++; $display("FAIL x_latency t=%0d: got %0b expected %0b", t, x, (t == 7)); end
        end
        if (t == 6 || t == 7) begin
          checks++;
          if (queue !== ((t == 7) ? 4'(v + 1) : 4'(v))) begin
            errors++; $display("FAIL arrive_edge v=%0d t=%0d: got %0d expected %0d", v, t, queue, (t == 7) ? v + 1 : v);
          end
        end
      end
      loop_raw = 1'b0;
      tick(10);
      checks++; if (queue !== 4'(v + 1) || x !== 1'b1) begin errors++; $display("FAIL arrivals v=%0d: got queue=%0d x=%0b expected %0d 1", v, queue, x, v + 1); end
    end
  endtask

  // Queue at 3, loop stuck under GREEN (rise ignored), async reset mid-cycle.
  task automatic test_reset_mid();
    cntry    = 2'd2;
    loop_raw = 1'b1;
    tick(75);
    checks++; if (queue !== 4'd3 || fault !== 1'b1) begin errors++; $display("FAIL pre_reset: got queue=%0d fault=%0b expected 3 1", queue, fault); end
    #2;
    clr_n    = 1'b0;
    loop_raw = 1'b0;
    #1;
    checks++; if (queue !== 4'd0 || x !== 1'b0 || fault !== 1'b0) begin
      errors++; $display("FAIL async_reset: got queue=%0d x=%0b fault=%0b expected 0 0 0", queue, x, fault);
    end
    @(negedge clk);
    clr_n = 1'b1;
    cntry = 2'd0;
    tick(3);
  endtask

  task automatic test_departures();
    int exp_q;
    int after_q;
    exp_q = 3;
    cntry = 2'd2;
    for (int v = 0; v < 4; v++) begin
      loop_raw = 1'b1;
      tick(10);
      checks++; if (queue !== 4'(exp_q)) begin errors++; $display("FAIL green_rise v=%0d: got %0d expected %0d", v, queue, exp_q); end
      after_q  = (exp_q > 0) ? exp_q - 1 : 0;
      loop_raw = 1'b0;
      for (int t = 1; t <= 10; t++) begin
        tick(1);
        checks++;
        if (queue !== 4'((t < 7) ? exp_q : after_q) || x !== (((t < 7) ? exp_q : after_q) != 0)) begin
          errors++; $display("FAIL depart v=%0d t=%0d: got queue=%0d x=%0b expected %0d", v, t, queue, x, (t < 7) ? exp_q : after_q);
        end
      end
      exp_q = after_q;
    end
  endtask

  // 17 arrivals alternating RED and light code 3 (also RED).
  task automatic test_saturation();
    int exp_q;
    exp_q = 0;
    for (int i = 0; i < 17; i++) begin
      cntry    = (i % 2 == 1) ? 2'd3 : 2'd0;
      loop_raw = 1'b1;
      tick(8);
      loop_raw = 1'b0;
      tick(8);
      exp_q = (exp_q < 15) ? exp_q + 1 : 15;
      checks++; if (queue !== 4'(exp_q) || x !== 1'b1) begin errors++; $display("FAIL saturate i=%0d: got queue=%0d x=%0b expected %0d 1", i, queue, x, exp_q); end
    end
  endtask

  task automatic test_stuck();
    do_reset();
    cntry    = 2'd0;
    loop_raw = 1'b1;
    for (int t = 1; t <= 100; t++) begin
      tick(1);
      if (t == 7) begin
        checks++; if (queue !== 4'd1 || x !== 1'b1) begin errors++; $display("FAIL stuck_arrival: got queue=%0d x=%0b expected 1 1", queue, x); end
      end
      if (t == 69 || t == 70 || t == 100) begin
        checks++; if (fault !== (t != 69) || x !== 1'b1) begin errors++; $display("FAIL stuck_fault t=%0d: got fault=%0b x=%0b expected %0b 1", t, fault, x, (t != 69)); end
      end
    end
    loop_raw = 1'b0;
    for (int t = 1; t <= 10; t++) begin
      tick(1);
      checks++;
      if (fault !== (t < 7) || queue !== 4'd1 || x !== 1'b1) begin
        errors++; $display("FAIL stuck_release t=%0d: got fault=%0b queue=%0d x=%0b expected %0b 1 1", t, fault, queue, x, (t < 7));
      end
    end
  endtask

  // Random vehicles and glitches with random light codes at rise and fall.
  task automatic test_random();
    int q;
    int hi;
    int lo;
    logic [1:0] c_rise;
    logic [1:0] c_fall;
    do_reset();
    q = 0;
    for (int i = 0; i < 40; i++) begin
      c_rise = 2'($urandom_range(0, 3));
      c_fall = 2'($urandom_range(0, 3));
      lo     = $urandom_range(8, 15);
      cntry  = c_rise;
      if ($urandom_range(0, 3) == 0) begin
        hi       = $urandom_range(1, 3);
        loop_raw = 1'b1;
        tick(hi);
        loop_raw = 1'b0;
        tick(lo);
      end else begin
        hi       = $urandom_range(8, 20);
        loop_raw = 1'b1;
        tick(hi);
        if (c_rise != 2'd2) q = (q < 15) ? q + 1 : 15;
        checks++; if (queue !== 4'(q)) begin errors++; $display("FAIL rand_rise i=%0d: got %0d expected %0d", i, queue, q); end
        cntry    = c_fall;
        loop_raw = 1'b0;
        tick(lo);
        if (c_fall == 2'd1 || c_fall == 2'd2) q = (q > 0) ? q - 1 : 0;
      end
      checks++;
      if (queue !== 4'(q) || x !== (q != 0) || fault !== 1'b0) begin
        errors++; $display("FAIL rand i=%0d: got queue=%0d x=%0b fault=%0b expected %0d %0b 0", i, queue, x, fault, q, (q != 0));
      end
    end
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    clr_n    = 1'b0;
    loop_raw = 1'b0;
    cntry    = 2'd0;
    test_reset();
    test_glitch();
    test_arrivals();
    test_reset_mid();
    test_arrivals();
    test_departures();
    test_saturation();
    test_stuck();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
